// File: rtl/wb_arbiter.sv
// Writeback arbiter: NR_FU per-unit result FIFOs merged onto NR_WB_PORTS scoreboard
// write ports, granted each cycle by round-robin or fixed priority.
module wb_arbiter #(
  parameter int NR_FU         = 4,
  parameter int NR_WB_PORTS   = 2,
  parameter int DATA_WIDTH    = 64,
  parameter int TRANS_ID_BITS = 3,
  parameter int FIFO_DEPTH    = 2,
  parameter int RR_MODE       = 1
) (
  input  logic                                 clk_i,
  input  logic                                 rst_ni,
  input  logic                                 flush_i,
  input  logic [NR_FU-1:0]                     fu_valid_i,
  output logic [NR_FU-1:0]                     fu_ready_o,
  input  logic [NR_FU*DATA_WIDTH-1:0]          fu_result_i,
  input  logic [NR_FU*TRANS_ID_BITS-1:0]       fu_trans_id_i,
  input  logic [NR_FU-1:0]                     fu_ex_valid_i,
  input  logic [NR_FU*DATA_WIDTH-1:0]          fu_ex_cause_i,
  output logic [NR_WB_PORTS-1:0]               wb_valid_o,
  output logic [NR_WB_PORTS*DATA_WIDTH-1:0]    wb_result_o,
  output logic [NR_WB_PORTS*TRANS_ID_BITS-1:0] wb_trans_id_o,
  output logic [NR_WB_PORTS-1:0]               wb_ex_valid_o,
  output logic [NR_WB_PORTS*DATA_WIDTH-1:0]    wb_ex_cause_o,
  output logic                                 conflict_o
);

  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int IDX_W = $clog2(NR_FU);

  logic [DATA_WIDTH-1:0]    res_mem   [NR_FU][FIFO_DEPTH];
  logic [DATA_WIDTH-1:0]    cause_mem [NR_FU][FIFO_DEPTH];
  logic [TRANS_ID_BITS-1:0] id_mem    [NR_FU][FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0]    ex_mem    [NR_FU];

  logic [CNT_W-1:0]       cnt    [NR_FU];
  logic [PTR_W-1:0]       wr_ptr [NR_FU];
  logic [PTR_W-1:0]       rd_ptr [NR_FU];
  logic [IDX_W-1:0]       rr_ptr;
  logic [IDX_W-1:0]       rr_next;
  logic [NR_FU-1:0]       push;
  logic [NR_FU-1:0]       grant;
  logic [NR_FU-1:0]       nonempty;
  logic [IDX_W-1:0]       port_ch [NR_WB_PORTS];
  logic [NR_WB_PORTS-1:0] port_used;

  // Pointers wrap explicitly so FIFO_DEPTH need not be a power of two.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(FIFO_DEPTH - 1)) return '0;
    return p + PTR_W'(1);
  endfunction

  always_comb begin
    for (int k = 0; k < NR_FU; k++) begin
      fu_ready_o[k] = (cnt[k] < CNT_W'(FIFO_DEPTH));
      nonempty[k]   = (cnt[k] != '0);
      push[k]       = fu_valid_i[k] & fu_ready_o[k];
    end
  end

  // Each port takes the first not-yet-taken non-empty channel in scan order.
  always_comb begin
    logic [IDX_W-1:0] ch;
    logic             found;
    int               start;
    grant     = '0;
    port_used = '0;
    rr_next   = rr_ptr;
    ch        = '0;
    found     = 1'b0;
    start     = (RR_MODE != 0) ? int'(rr_ptr) : 0;
    for (int p = 0; p < NR_WB_PORTS; p++) port_ch[p] = '0;
    for (int p = 0; p < NR_WB_PORTS; p++) begin
      found = 1'b0;
      for (int i = 0; i < NR_FU; i++) begin
        ch = IDX_W'((start + i) % NR_FU);
        if (!found && nonempty[ch] && !grant[ch]) begin
          found        = 1'b1;
          grant[ch]    = 1'b1;
          port_ch[p]   = ch;
          port_used[p] = 1'b1;
        end
      end
    end
    for (int p = 0; p < NR_WB_PORTS; p++) begin
      if (port_used[p]) rr_next = IDX_W'((int'(port_ch[p]) + 1) % NR_FU);
    end
    conflict_o = !flush_i && ($countones(nonempty) > NR_WB_PORTS);
  end

  always_comb begin
    wb_valid_o    = '0;
    wb_result_o   = '0;
    wb_trans_id_o = '0;
    wb_ex_valid_o = '0;
    wb_ex_cause_o = '0;
    for (int p = 0; p < NR_WB_PORTS; p++) begin
      if (port_used[p] && !flush_i) begin
        wb_valid_o[p]                                  = 1'b1;
        wb_result_o[p*DATA_WIDTH +: DATA_WIDTH]        = res_mem[port_ch[p]][rd_ptr[port_ch[p]]];
        wb_trans_id_o[p*TRANS_ID_BITS +: TRANS_ID_BITS] = id_mem[port_ch[p]][rd_ptr[port_ch[p]]];
        wb_ex_valid_o[p]                               = ex_mem[port_ch[p]][rd_ptr[port_ch[p]]];
        wb_ex_cause_o[p*DATA_WIDTH +: DATA_WIDTH]      = cause_mem[port_ch[p]][rd_ptr[port_ch[p]]];
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int k = 0; k < NR_FU; k++) begin
        cnt[k]    <= '0;
        wr_ptr[k] <= '0;
        rd_ptr[k] <= '0;
      end
      rr_ptr <= '0;
    end else if (flush_i) begin
      for (int k = 0; k < NR_FU; k++) begin
        cnt[k]    <= '0;
        wr_ptr[k] <= '0;
        rd_ptr[k] <= '0;
      end
      rr_ptr <= '0;
    end else begin
      for (int k = 0; k < NR_FU; k++) begin
        if (push[k])  wr_ptr[k] <= ptr_inc(wr_ptr[k]);
        if (grant[k]) rd_ptr[k] <= ptr_inc(rd_ptr[k]);
        if (push[k] && !grant[k])      cnt[k] <= cnt[k] + CNT_W'(1);
        else if (!push[k] && grant[k]) cnt[k] <= cnt[k] - CNT_W'(1);
      end
      if (|grant) rr_ptr <= rr_next;
    end
  end

  // Payload storage carries no reset; empty entries are never presented.
  always_ff @(posedge clk_i) begin
    for (int k = 0; k < NR_FU; k++) begin
      if (push[k] && !flush_i) begin
        res_mem[k][wr_ptr[k]]   <= fu_result_i[k*DATA_WIDTH +: DATA_WIDTH];
        cause_mem[k][wr_ptr[k]] <= fu_ex_cause_i[k*DATA_WIDTH +: DATA_WIDTH];
        id_mem[k][wr_ptr[k]]    <= fu_trans_id_i[k*TRANS_ID_BITS +: TRANS_ID_BITS];
        ex_mem[k][wr_ptr[k]]    <= fu_ex_valid_i[k];
      end
    end
  end

endmodule
